c2hdl_call_seq: RTL and testbench

Call sequencer for a c2hdl-generated kernel core. A host or testbench pushes call descriptors (entry pc, return address, a0, sp) into a small queue, and the block launches them on the core one at a time. For each call it drives the core's `pc0`/`ra0`/`a00`/`sp0`/`setb`, waits for `idle`, and records completion and cycle count. It sits between the host control path and the generated core. The core's memory bus is untouched.

---
 rtl/c2hdl_call_seq.sv | 201 ++++++++++++++++++++
 tb/tb_c2hdl_call_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/c2hdl_call_seq.sv
// c2hdl_call_seq -- call sequencer for a c2hdl-generated kernel core.
//
// A host pushes call descriptors {pc, ra, a0, sp} into a small FIFO. Calls
// are launched on the core one at a time: the descriptor is driven on
// pc0/ra0/a00/sp0 with setb low for GAP cycles, then setb is raised. Once
// the core reports idle, setb is held for GAP more cycles and then dropped.
// Completion is reported with a done pulse, a completion counter and the
// cycle count of the last call.
//
// Optional feature macro: CALL_SEQ_TIMEOUT_EN enables a WAIT watchdog of
// TMO cycles that aborts a hung call and sets a sticky err flag.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            descriptor push handshake
//   cmd_pc/cmd_ra/cmd_a0/cmd_sp    descriptor fields
//   pc0/ra0/a00/sp0/setb           launch interface to the core
//   idle                           core idle indication
//   busy                           call in flight or queue non-empty
//   done                           one-cycle pulse per finished call
//   done_cnt                       completed calls since reset (wraps)
//   cyc_last                       setb-rise-to-idle cycles of last call
//   pending                        queue occupancy
//   err                            sticky watchdog abort
module c2hdl_call_seq #(
  parameter int PCW   = 10,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int GAP   = 3,
  parameter int TMO   = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [PCW-1:0]             cmd_pc,
  input  logic [AW-1:0]              cmd_ra,
  input  logic [AW-1:0]              cmd_a0,
  input  logic [AW-1:0]              cmd_sp,
  output logic [PCW-1:0]             pc0,
  output logic [AW-1:0]              ra0,
  output logic [AW-1:0]              a00,
  output logic [AW-1:0]              sp0,
  output logic                       setb,
  input  logic                       idle,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                done_cnt,
  output logic [31:0]                cyc_last,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_RUN, S_WAIT, S_HOLD
  } state_t;

  // ---------------------------------------------------------------------
  // Descriptor FIFO. Pointers wrap naturally since DEPTH is a power of two;
  // occupancy is tracked separately so full and empty are unambiguous.
  // ---------------------------------------------------------------------
  logic [PCW-1:0] q_pc [DEPTH];
  logic [AW-1:0]  q_ra [DEPTH];
  logic [AW-1:0]  q_a0 [DEPTH];
  logic [AW-1:0]  q_sp [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           push, pop;
  state_t         state;

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  // The only consumer is the FSM, and it enters LOAD only with a non-empty queue.
  assign pop       = (state == S_LOAD);
  assign pending   = count;
  assign busy      = (state != S_IDLE) | (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr] <= cmd_pc;
      q_ra[wr_ptr] <= cmd_ra;
      q_a0[wr_ptr] <= cmd_a0;
      q_sp[wr_ptr] <= cmd_sp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ---------------------------------------------------------------------
  // Launch FSM. All core-facing outputs are registered here.
  // ---------------------------------------------------------------------
  logic [GW-1:0] gcnt;     // SETUP / HOLD gap counter
  logic [31:0]   cnt;      // cycles since RUN (RUN itself counts as 1)
  logic [31:0]   cnt_inc;  // saturating increment
  logic          first;    // first WAIT cycle: core has not dropped idle yet

  always_comb begin
    cnt_inc = (&cnt) ? cnt : cnt + 32'd1;
  end

`ifdef CALL_SEQ_TIMEOUT_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_tmo;
  assign err        = 1'b0;
  assign unused_tmo = (TMO != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc0      <= '0;
      ra0      <= '0;
      a00      <= '0;
      sp0      <= '0;
      setb     <= 1'b0;
      done     <= 1'b0;
      done_cnt <= '0;
      cyc_last <= '0;
      gcnt     <= '0;
      cnt      <= '0;
      first    <= 1'b0;
`ifdef CALL_SEQ_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (count != '0) state <= S_LOAD;
        S_LOAD: begin
          pc0   <= q_pc[rd_ptr];
          ra0   <= q_ra[rd_ptr];
          a00   <= q_a0[rd_ptr];
          sp0   <= q_sp[rd_ptr];
          gcnt  <= '0;
          state <= S_SETUP;
        end
        S_SETUP: begin
          if (gcnt == GW'(GAP - 1)) begin
            setb  <= 1'b1;
            state <= S_RUN;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_RUN: begin
          cnt   <= 32'd1;
          first <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt   <= cnt_inc;
          first <= 1'b0;
          if (idle && !first) begin
            cyc_last <= cnt_inc;
            gcnt     <= '0;
            state    <= S_HOLD;
          end
`ifdef CALL_SEQ_TIMEOUT_EN
          // cnt equals the WAIT cycle index here, so this fires on the
          // TMO-th WAIT cycle without idle.
          else if (cnt == 32'(TMO)) begin
            setb     <= 1'b0;
            err_q    <= 1'b1;
            cyc_last <= '1;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
`endif
        end
        S_HOLD: begin
          if (gcnt == GW'(GAP - 1)) begin
            setb     <= 1'b0;
            done     <= 1'b1;
            done_cnt <= done_cnt + 16'd1;
            state    <= S_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c2hdl_call_seq.sv
module tb_c2hdl_call_seq;
  localparam int PCW = 10, AW = 32, DEPTH = 4, GAP = 3, TMO = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [PCW-1:0] cmd_pc = '0;
  logic [AW-1:0]  cmd_ra = '0, cmd_a0 = '0, cmd_sp = '0;
  logic [PCW-1:0] pc0;
  logic [AW-1:0]  ra0, a00, sp0;
  logic           setb;
  logic           idle = 1'b1;
  logic           busy, done, err;
  logic [15:0]    done_cnt;
  logic [31:0]    cyc_last;
  logic [2:0]     pending;

  c2hdl_call_seq #(.PCW(PCW), .AW(AW), .DEPTH(DEPTH), .GAP(GAP), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_pc(cmd_pc), .cmd_ra(cmd_ra), .cmd_a0(cmd_a0), .cmd_sp(cmd_sp),
    .pc0(pc0), .ra0(ra0), .a00(a00), .sp0(sp0), .setb(setb), .idle(idle),
    .busy(busy), .done(done), .done_cnt(done_cnt), .cyc_last(cyc_last),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [AW-1:0]  ra, a0, sp;
    logic [31:0]    cyc;
    bit             abort;
  } rec_t;

  rec_t           sb[$];
  logic [PCW-1:0] launched[$];
  int             n_vec = 0, n_bad = 0;
  int             core_lat = 20;
  bit             core_hang = 1'b0;
  int             cctr = 0;
  logic [15:0]    exp_done = '0;
  bit             saw_full = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Core model: idle drops once setb is seen, and returns core_lat WAIT
  // cycles after the RUN cycle (cyc_last = core_lat + 1).
  always @(negedge clk) begin
    if (!setb) begin
      cctr = 0;
      idle = 1'b1;
    end else begin
      cctr++;
      idle = !core_hang && (cctr > core_lat);
    end
  end

  // Monitor: checks launches and completions against the scoreboard.
  logic           prev_setb = 1'b0;
  logic [PCW-1:0] run_pc = '0;
  rec_t           mon_r;
  always @(negedge clk) begin
    if (rst) begin
      prev_setb = 1'b0;
    end else begin
      chk("ready_vs_pending", cmd_ready, (pending != 3'(DEPTH)));
      if (pending == 3'(DEPTH)) saw_full = 1'b1;
      if (setb && !prev_setb) begin
        chk("launch_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("launch_pc", pc0, sb[0].pc);
          chk("launch_ra", ra0, sb[0].ra);
          chk("launch_a0", a00, sb[0].a0);
          chk("launch_sp", sp0, sb[0].sp);
        end
        run_pc = pc0;
        launched.push_back(pc0);
      end else if (setb && prev_setb) begin
        chk("pc_stable", pc0, run_pc);
      end
      if (done) begin
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_r = sb.pop_front();
          chk("done_setb_low", setb, 0);
          chk("cyc_last", cyc_last, mon_r.cyc);
          if (mon_r.abort) chk("err_on_abort", err, 1);
          else exp_done++;
          chk("done_cnt", done_cnt, exp_done);
        end
      end
      prev_setb = setb;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    sb.delete(); exp_done = '0; core_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for space, then pushes; returns just after the push edge.
  task automatic push(input logic [PCW-1:0] pc, input logic [AW-1:0] ra,
                      input logic [AW-1:0] a0, input logic [AW-1:0] sp, input bit abort);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 2000) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    else begin
      cmd_valid = 1'b1; cmd_pc = pc; cmd_ra = ra; cmd_a0 = a0; cmd_sp = sp;
      sb.push_back('{pc, ra, a0, sp, abort ? 32'hffff_ffff : 32'(core_lat + 1), abort});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((busy || sb.size() != 0) && c < maxc) begin @(negedge clk); c++; end
    chk("drain_busy", busy, 0);
    chk("drain_sb", sb.size(), 0);
  endtask

  task automatic wait_setb(input int maxc);
    int c = 0;
    @(negedge clk);
    while (!setb && c < maxc) begin @(negedge clk); c++; end
    chk("wait_setb", setb, 1);
  endtask

  task automatic wait_done(input int maxc, output int c);
    c = 0;
    @(negedge clk);
    while (!done && c < maxc) begin @(negedge clk); c++; end
    chk("wait_done", done, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int c;
    // ---- reset values
    repeat (3) @(negedge clk);
    chk("rst_setb", setb, 0);      chk("rst_pc0", pc0, 0);
    chk("rst_ra0", ra0, 0);        chk("rst_a00", a00, 0);
    chk("rst_sp0", sp0, 0);        chk("rst_done", done, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_cyc_last", cyc_last, 0);
    chk("rst_pending", pending, 0); chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);      chk("rst_err", err, 0);
    rst = 1'b0;

    // ---- single call, launch latency GAP+2 = 5
    core_lat = 20;
    push(10'h000, 32'h44, 32'h1000, 32'h1ffc, 0);
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      chk("launch_latency", setb, (i == 5));
    end
    drain(200);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_cyc_last", cyc_last, 21);

    // ---- 75 calls, back-pressure, order by a0
    do_reset();
    core_lat = 4; saw_full = 1'b0;
    for (int i = 0; i < 75; i++) push(10'h010, 32'h44, 32'(i), 32'h1ffc, 0);
    drain(3000);
    chk("t2_saw_full", saw_full, 1);
    chk("t2_done_cnt", done_cnt, 75);

    // ---- three distinct pcs in order
    core_lat = 6;
    launched.delete();
    push(10'h000, 32'h44, 32'h1, 32'h100, 0);
    push(10'h2bc, 32'h48, 32'h2, 32'h200, 0);
    push(10'h044, 32'h4c, 32'h3, 32'h300, 0);
    drain(300);
    chk("t3_n_launch", launched.size(), 3);
    if (launched.size() == 3) begin
      chk("t3_pc_0", launched[0], 10'h000);
      chk("t3_pc_1", launched[1], 10'h2bc);
      chk("t3_pc_2", launched[2], 10'h044);
    end

    // ---- reset in mid-WAIT
    do_reset();
    core_lat = 50;
    push(10'h011, 32'h44, 32'h1, 32'h100, 0);
    push(10'h022, 32'h44, 32'h2, 32'h100, 0);
    push(10'h033, 32'h44, 32'h3, 32'h100, 0);
    wait_setb(50);
    repeat (5) @(negedge clk);
    rst = 1'b1; sb.delete(); exp_done = '0;
    @(negedge clk);
    chk("t4_setb", setb, 0);   chk("t4_pending", pending, 0);
    chk("t4_done", done, 0);   chk("t4_done_cnt", done_cnt, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_idle_after", busy, 0);
    chk("t4_done_cnt_after", done_cnt, 0);

    // ---- push during LOAD with pending = 4: rejected
    core_lat = 30;
    push(10'h100, 32'h44, 32'h10, 32'h100, 0);
    wait_setb(50);
    for (int i = 1; i <= 4; i++) push(10'(10'h100 + i), 32'h44, 32'(16 + i), 32'h100, 0);
    @(negedge clk);
    chk("t6_full_pending", pending, 4);
    chk("t6_full_ready", cmd_ready, 0);
    wait_done(200, c);
    @(negedge clk);   // LOAD cycle
    chk("t6_load_pending4", pending, 4);
    chk("t6_load_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_pc = 10'h3ff;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_rejected_pending", pending, 3);
    drain(1000);

    // ---- push during LOAD with pending = 2: stays 2
    push(10'h200, 32'h44, 32'h20, 32'h100, 0);
    wait_setb(50);
    push(10'h201, 32'h44, 32'h21, 32'h100, 0);
    push(10'h202, 32'h44, 32'h22, 32'h100, 0);
    wait_done(200, c);
    @(negedge clk);   // LOAD cycle
    chk("t6_load_pending2", pending, 2);
    chk("t6_load_ready2", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_pc = 10'h203; cmd_ra = 32'h44; cmd_a0 = 32'h23; cmd_sp = 32'h100;
    sb.push_back('{10'h203, 32'h44, 32'h23, 32'h100, 32'(core_lat + 1), 0});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t6_same_pending", pending, 2);
    drain(1000);

`ifdef CALL_SEQ_TIMEOUT_EN
    // ---- watchdog: hung call aborted, next call completes
    do_reset();
    core_hang = 1'b1; core_lat = 8;
    push(10'h0aa, 32'h44, 32'h1, 32'h100, 1);
    push(10'h0bb, 32'h44, 32'h2, 32'h100, 0);
    wait_setb(50);
    wait_done(300, c);
    core_hang = 1'b0;
    chk("t5_abort_cycles", c, 100);
    chk("t5_err", err, 1);
    chk("t5_cyc_last", cyc_last, 32'hffff_ffff);
    chk("t5_done_cnt_abort", done_cnt, 0);
    drain(300);
    chk("t5_err_sticky", err, 1);
    chk("t5_done_cnt", done_cnt, 1);
`else
    chk("no_watchdog_err", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
